db_mv_ram_sp_arb: RTL

Parametrised single-port motion-vector RAM for the deblocking MV store, successor to the fixed 64x20 single-port macro wrapper. It adds independent read and write request channels arbitrated onto one physical port, a one-entry write buffer with read forwarding, a registered read-valid strobe and an optional hardware clear sequencer. It sits between the MV writer (CU/PU decision side) and the deblocking boundary-strength reader.

---
 rtl/db_mv_ram_sp_arb_if.sv | 45 ++++
 rtl/db_mv_ram_sp_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/db_mv_ram_sp_arb_if.sv
// Request/response bundle for db_mv_ram_sp_arb: clear control, write channel and read channel.
// master = MV writer / BS reader side, slave = the RAM arbiter.
interface db_mv_ram_sp_arb_if #(
  parameter int DW = 20,
  parameter int AW = 6
);

  logic          clr_i;
  logic          busy_o;
  logic          wr_req_i;
  logic          wr_rdy_o;
  logic [AW-1:0] wr_adr_i;
  logic [DW-1:0] wr_dat_i;
  logic          rd_req_i;
  logic [AW-1:0] rd_adr_i;
  logic          rd_vld_o;
  logic [DW-1:0] rd_dat_o;

  modport master (
    output clr_i,
    input  busy_o,
    output wr_req_i,
    input  wr_rdy_o,
    output wr_adr_i,
    output wr_dat_i,
    output rd_req_i,
    output rd_adr_i,
    input  rd_vld_o,
    input  rd_dat_o
  );

  modport slave (
    input  clr_i,
    output busy_o,
    input  wr_req_i,
    output wr_rdy_o,
    input  wr_adr_i,
    input  wr_dat_i,
    input  rd_req_i,
    input  rd_adr_i,
    output rd_vld_o,
    output rd_dat_o
  );

endinterface

// File: rtl/db_mv_ram_sp_arb.sv
// Single-port deblocking MV RAM: read/write channels arbitrated onto one port, one-entry write
// buffer with read forwarding. Optional clear sweep FSM enabled by defining DB_MV_RAM_CLR_EN.
module db_mv_ram_sp_arb #(
  parameter int DW = 20,
  parameter int AW = 6
) (
  input  logic              clk,
  input  logic              rstn,
  db_mv_ram_sp_arb_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];

  logic          buf_vld_q, buf_vld_d;
  logic [AW-1:0] buf_adr_q, buf_adr_d;
  logic [DW-1:0] buf_dat_q, buf_dat_d;
  logic          rd_vld_q, rd_vld_d;
  logic [DW-1:0] rd_dat_q, rd_dat_d;

  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdat;

  logic          sweep_drain;
  logic          sweep_zero;
  logic [AW-1:0] sweep_adr;
  logic          busy;
  logic          wr_acc;

`ifdef DB_MV_RAM_CLR_EN
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLR   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  assign sweep_drain = (state_q == ST_DRAIN);
  assign sweep_zero  = (state_q == ST_CLR);
  assign sweep_adr   = cnt_q;
  assign busy        = sweep_drain | sweep_zero;

  // A write that enters the buffer in the clr_i cycle also goes through DRAIN, so it is cleared too.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_i) begin
          state_d = (buf_vld_q | buf_vld_d) ? ST_DRAIN : ST_CLR;
        end
      end
      ST_DRAIN: state_d = ST_CLR;
      ST_CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_clr;

  assign unused_clr  = bus.clr_i;
  assign sweep_drain = 1'b0;
  assign sweep_zero  = 1'b0;
  assign sweep_adr   = '0;
  assign busy        = 1'b0;
`endif

  assign wr_acc = bus.wr_req_i & bus.wr_rdy_o;

  // Port arbitration: sweep > read > buffer drain > new write.
  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_adr_d = buf_adr_q;
    buf_dat_d = buf_dat_q;
    rd_vld_d  = bus.rd_req_i & ~busy;
    rd_dat_d  = rd_dat_q;
    mem_we    = 1'b0;
    mem_adr   = bus.wr_adr_i;
    mem_wdat  = bus.wr_dat_i;

    if (sweep_drain) begin
      mem_we    = 1'b1;
      mem_adr   = buf_adr_q;
      mem_wdat  = buf_dat_q;
      buf_vld_d = 1'b0;
    end else if (sweep_zero) begin
      mem_we   = 1'b1;
      mem_adr  = sweep_adr;
      mem_wdat = '0;
    end else if (bus.rd_req_i) begin
      if (wr_acc) begin
        buf_vld_d = 1'b1;
        buf_adr_d = bus.wr_adr_i;
        buf_dat_d = bus.wr_dat_i;
      end
      if (wr_acc && (bus.wr_adr_i == bus.rd_adr_i)) begin
        rd_dat_d = bus.wr_dat_i;
      end else if (buf_vld_q && (buf_adr_q == bus.rd_adr_i)) begin
        rd_dat_d = buf_dat_q;
      end else begin
        rd_dat_d = mem_q[bus.rd_adr_i];
      end
    end else if (buf_vld_q) begin
      mem_we    = 1'b1;
      mem_adr   = buf_adr_q;
      mem_wdat  = buf_dat_q;
      buf_vld_d = 1'b0;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_vld_q <= 1'b0;
      buf_adr_q <= '0;
      buf_dat_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_adr_q <= buf_adr_d;
      buf_dat_q <= buf_dat_d;
      rd_vld_q  <= rd_vld_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

  // The array itself has no reset; writes are only suppressed while rstn is low.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      mem_q[mem_adr] <= mem_wdat;
    end
  end

  assign bus.busy_o   = busy;
  assign bus.wr_rdy_o = ~buf_vld_q & ~busy;
  assign bus.rd_vld_o = rd_vld_q;
  assign bus.rd_dat_o = rd_dat_q;

endmodule
